// File: rtl/svf_mul_clip.sv
`default_nettype none
// ============================================================================
//  Module   : svf_mul_clip
//  Purpose  : Arithmetic datapath for the state-variable filter.
//             - Signed (17b) x unsigned Q0.16 (16b) coefficient multiplier.
//               The product is floor-scaled by 2^-16, saturated to signed 16b
//               and registered: 1 clock latency, one new operation per clock.
//             - Three combinational 17b -> 16b saturating clippers that
//               produce the lowpass/bandpass/highpass outputs.
//  Ports    :
//    clk      in   1   system clock, rising edge
//    rst      in   1   synchronous reset, active-high (clears oMul only)
//    iSignal  in  17   signed multiplier operand
//    iCoef    in  16   unsigned coefficient, fraction scaled by 0x10000
//    oMul     out 16   registered, saturated signed product
//    iLow     in  17   signed lowpass accumulator
//    iBand    in  17   signed bandpass accumulator
//    iHigh    in  17   signed highpass accumulator
//    oLP      out 16   clipped iLow
//    oBP      out 16   clipped iBand
//    oHP      out 16   clipped iHigh
//  Revision : 1.0  initial release
// ============================================================================
module svf_mul_clip (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [16:0] iSignal,
    input  logic        [15:0] iCoef,
    output logic signed [15:0] oMul,
    input  logic signed [16:0] iLow,
    input  logic signed [16:0] iBand,
    input  logic signed [16:0] iHigh,
    output logic signed [15:0] oLP,
    output logic signed [15:0] oBP,
    output logic signed [15:0] oHP
);

    localparam int                 c_NUM_CLIP = 3;
    localparam logic signed [33:0] c_MAX_POS  = 34'sd32767;
    localparam logic signed [33:0] c_MAX_NEG  = -34'sd32768;

    // ------------------------------------------------------------------
    // Multiplier
    // Both operands are extended to 34 bits so the multiply is a plain
    // signed multiply; the coefficient gets zero extension so 0x8000..0xFFFF
    // stay positive fractions. The true product fits in 33 bits.
    // ------------------------------------------------------------------
    logic signed [33:0] w_sigExt;
    logic signed [33:0] w_coefExt;
    logic signed [33:0] w_prod;
    logic signed [33:0] w_quot;
    logic signed [15:0] w_mulSat;

    assign w_sigExt  = {{17{iSignal[16]}}, iSignal};
    assign w_coefExt = {18'd0, iCoef};
    assign w_prod    = w_sigExt * w_coefExt;
    // Arithmetic shift gives floor division, so -1 * 1 yields -1, not 0.
    assign w_quot    = w_prod >>> 16;

    always_comb begin
        w_mulSat = w_quot[15:0];
        if (w_quot > c_MAX_POS) begin
            w_mulSat = 16'sh7FFF;
        end else if (w_quot < c_MAX_NEG) begin
            w_mulSat = 16'sh8000;
        end
    end

    logic signed [15:0] r_mul;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul <= '0;
        end else begin
            r_mul <= w_mulSat;
        end
    end

    assign oMul = r_mul;

    // ------------------------------------------------------------------
    // Clippers
    // A 17-bit value fits in 16 bits exactly when its top two bits agree;
    // otherwise the sign bit picks which rail to clamp to.
    // ------------------------------------------------------------------
    function automatic logic [15:0] clip17to16(input logic [16:0] din);
        logic [15:0] result;
        if (din[16] != din[15]) begin
            result = din[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            result = din[15:0];
        end
        return result;
    endfunction

    logic [16:0] w_clipIn  [c_NUM_CLIP];
    logic [15:0] w_clipOut [c_NUM_CLIP];

    assign w_clipIn[0] = iLow;
    assign w_clipIn[1] = iBand;
    assign w_clipIn[2] = iHigh;

    generate
        for (genvar gi = 0; gi < c_NUM_CLIP; gi++) begin : g_clip
            assign w_clipOut[gi] = clip17to16(w_clipIn[gi]);
        end
    endgenerate

    assign oLP = w_clipOut[0];
    assign oBP = w_clipOut[1];
    assign oHP = w_clipOut[2];

endmodule
`default_nettype wire

// File: tb/tb_svf_mul_clip.sv
`default_nettype none
// ============================================================================
//  Module   : tb_svf_mul_clip
//  Purpose  : Self-checking bench for svf_mul_clip. Table-driven multiplier
//             and clipper vectors, hand-written reset/pipeline sequences,
//             and randomized comparison against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_svf_mul_clip;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [16:0] iSignal;
    logic        [15:0] iCoef;
    logic signed [15:0] oMul;
    logic signed [16:0] iLow;
    logic signed [16:0] iBand;
    logic signed [16:0] iHigh;
    logic signed [15:0] oLP;
    logic signed [15:0] oBP;
    logic signed [15:0] oHP;

    int checks = 0;
    int errors = 0;

    svf_mul_clip dut (
        .clk     (clk),
        .rst     (rst),
        .iSignal (iSignal),
        .iCoef   (iCoef),
        .oMul    (oMul),
        .iLow    (iLow),
        .iBand   (iBand),
        .iHigh   (iHigh),
        .oLP     (oLP),
        .oBP     (oBP),
        .oHP     (oHP)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sig;
        int coef;
        int expMul;
    } mulVec_t;

    typedef struct {
        int din;
        int expOut;
    } clipVec_t;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: floor(sig * coef / 65536), saturated to signed 16 bits.
    function automatic int mulModel(input int sig, input int coef);
        longint p;
        longint q;
        p = longint'(sig) * longint'(coef);
        q = p >>> 16;
        if (q > 32767)  return 32767;
        if (q < -32768) return -32768;
        return int'(q);
    endfunction

    function automatic int clipModel(input int din);
        if (din > 32767)  return 32767;
        if (din < -32768) return -32768;
        return din;
    endfunction

    // Apply one operand pair, clock it, and check the registered result.
    task automatic mulStep(input string name, input int sig, input int coef, input int exp);
        iSignal = 17'(sig);
        iCoef   = 16'(coef);
        @(posedge clk);
        #1;
        check(name, int'(oMul), exp);
    endtask

    mulVec_t  mulTab  [12];
    clipVec_t clipTab [8];

    initial begin
        mulTab[0]  = '{ 16384,  'h8000,   8192};
        mulTab[1]  = '{-16384,  'h8000,  -8192};
        mulTab[2]  = '{  1000,  'hFFFF,    999};
        mulTab[3]  = '{    -1,  'h0001,     -1};
        mulTab[4]  = '{ 65535,  'hFFFF,  32767};
        mulTab[5]  = '{-65536,  'hFFFF, -32768};
        mulTab[6]  = '{ 40000,  'hE000,  32767};
        mulTab[7]  = '{-40000,  'hE000, -32768};
        mulTab[8]  = '{ 32767,  'hFFFF,  32766};
        mulTab[9]  = '{-32768,  'h8000, -16384};
        mulTab[10] = '{ 12345,  'h0000,      0};
        mulTab[11] = '{    -3,  'h5555,     -1};

        clipTab[0] = '{ 40000,  32767};
        clipTab[1] = '{-40000, -32768};
        clipTab[2] = '{  1234,   1234};
        clipTab[3] = '{ 32767,  32767};
        clipTab[4] = '{-32768, -32768};
        clipTab[5] = '{ 32768,  32767};
        clipTab[6] = '{-32769, -32768};
        clipTab[7] = '{     0,      0};

        rst     = 1'b1;
        iSignal = 17'sd1000;
        iCoef   = 16'hFFFF;
        iLow    = '0;
        iBand   = '0;
        iHigh   = '0;

        // ---------------- Reset ----------------
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_oMul", int'(oMul), 0);
        end
        rst     = 1'b0;
        mulStep("reset_release_zero", 0, 'hFFFF, 0);

        // ---------------- Table-driven products ----------------
        for (int i = 0; i < 12; i++) begin
            mulStep($sformatf("mul_vec%0d", i), mulTab[i].sig, mulTab[i].coef, mulTab[i].expMul);
        end

        // ---------------- Pipeline lag + mid-stream reset ----------------
        mulStep("pipe_100", 100, 'h8000, 50);
        iSignal = 17'sd200;
        #1;
        check("pipe_hold_before_edge", int'(oMul), 50);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("pipe_reset_mid", int'(oMul), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("pipe_resume_200", int'(oMul), 100);
        iSignal = -17'sd300;
        #1;
        check("pipe_lag_one_edge", int'(oMul), 100);
        @(posedge clk);
        #1;
        check("pipe_neg300", int'(oMul), -150);

        // ---------------- Clipper table (no clock edges needed) ----------------
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            iLow  = 17'(clipTab[i].din);
            iBand = 17'(clipTab[(i + 1) % 8].din);
            iHigh = 17'(clipTab[(i + 2) % 8].din);
            #1;
            check($sformatf("clip_lp%0d", i), int'(oLP), clipTab[i].expOut);
            check($sformatf("clip_bp%0d", i), int'(oBP), clipTab[(i + 1) % 8].expOut);
            check($sformatf("clip_hp%0d", i), int'(oHP), clipTab[(i + 2) % 8].expOut);
        end

        // Independence: moving one channel must leave the others alone.
        iLow  = 17'sd40000;
        iBand = -17'sd40000;
        iHigh = 17'sd1234;
        #1;
        iLow = -17'sd5;
        #1;
        check("indep_lp", int'(oLP), -5);
        check("indep_bp", int'(oBP), -32768);
        check("indep_hp", int'(oHP), 1234);

        // ---------------- Random multiplier ----------------
        for (int n = 0; n < 10000; n++) begin
            logic signed [16:0] rs;
            logic        [15:0] rc;
            rs = 17'($urandom_range(0, 131071));
            rc = 16'($urandom_range(0, 65535));
            iSignal = rs;
            iCoef   = rc;
            @(posedge clk);
            #1;
            check("rand_mul", int'(oMul), mulModel(int'(rs), int'({1'b0, rc})));
        end

        // ---------------- Random clippers ----------------
        for (int n = 0; n < 500; n++) begin
            logic signed [16:0] a;
            logic signed [16:0] b;
            logic signed [16:0] c;
            a = 17'($urandom_range(0, 131071));
            b = 17'($urandom_range(0, 131071));
            c = 17'($urandom_range(0, 131071));
            iLow  = a;
            iBand = b;
            iHigh = c;
            #1;
            check("rand_lp", int'(oLP), clipModel(int'(a)));
            check("rand_bp", int'(oBP), clipModel(int'(b)));
            check("rand_hp", int'(oHP), clipModel(int'(c)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/svf_mul_clip.md
Name: svf_mul_clip

Overview:
Arithmetic datapath for the state-variable filter. It contains two parts:
- A signed-by-unsigned coefficient multiplier with a registered, saturated 16-bit result.
- Three independent combinational 17-to-16-bit saturating clippers that produce the lowpass, bandpass and highpass outputs.

The filter sequencer drives the multiplier operands and consumes the multiplier result. It also feeds its 17-bit low/band/high accumulators to the clippers.

Parameters:
None. All widths are fixed: operand 17-bit signed, coefficient 16-bit unsigned Q0.16, outputs 16-bit signed.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
iSignal  input  17  signed multiplier operand (filter state/sample)
iCoef  input  16  unsigned coefficient, fraction scaled by 0x10000
oMul  output  16  signed registered product, saturated
iLow  input  17  signed lowpass accumulator
iBand  input  17  signed bandpass accumulator
iHigh  input  17  signed highpass accumulator
oLP  output  16  clipped iLow
oBP  output  16  clipped iBand
oHP  output  16  clipped iHigh

Behaviour:
- Synchronous reset: on a rising edge with rst=1, the oMul register clears to 0.
  - rst has priority over the product load.
  - Clipper outputs are combinational and are not affected by reset.
- Multiplier arithmetic:
  - P = iSignal * iCoef: 33-bit signed product, with iCoef zero-extended (treated as unsigned).
  - Q = P arithmetic-shifted right by 16, i.e. floor division by 65536. Range is -65535..65534.
  - R = Q saturated to signed 16-bit: Q > 32767 gives 32767; Q < -32768 gives -32768; otherwise Q.
- Multiplier timing:
  - oMul is registered. On every rising edge with rst=0, oMul <= R computed from the iSignal/iCoef values present before that edge.
  - Latency is 1 clock from operands being stable to the result being visible.
  - An operand register written by the sequencer at edge N is therefore readable as oMul after edge N+1 (2 cycles from setting to use).
  - No enable and no handshake: a new operation is accepted every cycle (fully pipelined, throughput 1/clock).
  - oMul holds a stable value for the whole cycle between edges.
- Clippers (three identical instances):
  - Combinational, no clock.
  - out = 32767 if in > 32767; -32768 if in < -32768; else in[15:0].
  - Saturation detect: in[16] != in[15].
  - Sign bit in[16] selects the limit: 0 gives 0x7FFF, 1 gives 0x8000.
  - Boundary inputs map exactly to themselves: 32767 to 32767, -32768 to -32768.
- Zero coefficient yields 0 for any operand; zero operand yields 0 for any coefficient.
- Negative operands round toward minus infinity. Example: -1*1 gives -1, not 0.
- Reset asserted mid-stream:
  - oMul is 0 after that edge.
  - The first edge with rst=0 loads the product of the then-present operands.
- Implementation may map the multiply onto a hard DSP/MAC primitive. The result must be bit-exact with the above and keep exactly 1 cycle of latency.
- No X propagation on outputs after the first reset edge.

Test Plan:
1. Reset: assert rst for 2 edges with arbitrary operands -> oMul=0. Release rst with iSignal=0, iCoef=0xFFFF -> oMul stays 0.
2. Basic products, one result checked per edge after application:
   - iSignal=16384, iCoef=0x8000 -> oMul=8192
   - iSignal=-16384, iCoef=0x8000 -> -8192
   - iSignal=1000, iCoef=0xFFFF -> 999
   - iSignal=-1, iCoef=1 -> -1
3. Saturation and full range:
   - iSignal=65535, iCoef=0xFFFF -> 32767
   - iSignal=-65536, iCoef=0xFFFF -> -32768
   - iSignal=40000, iCoef=0xE000 -> 32767 (Q=35000)
   - iSignal=-40000, iCoef=0xE000 -> -32768
4. Pipeline: change operands every cycle through the sequence (100,0x8000), (200,0x8000), (-300,0x8000) -> oMul shows 50, 100, -150 on successive edges, each lagging its operands by exactly one edge. Assert rst for one edge mid-sequence -> oMul=0 on that edge, then streaming resumes.
5. Clippers:
   - iLow=40000 -> oLP=32767
   - iBand=-40000 -> oBP=-32768
   - iHigh=1234 -> oHP=1234
   - boundaries 32767, -32768, 32768, -32769 -> 32767, -32768, 32767, -32768
   - channels are independent and update combinationally with no clock.
6. Random: 10k random iSignal/iCoef pairs compared against a reference model of floor(iSignal*iCoef/65536) saturated, with one-cycle alignment. Random 17-bit clipper inputs compared against the saturate model.
